rx_frame_timer: RTL and testbench
=================================

// Module: rx_frame_timer
// PURPOSE
//  Receive-side timing and control for the serial receiver. It sits between the start-bit
//  detector and the shift register / receive buffer.
//  - Once a start bit is flagged, it paces the bit period.
//  - It emits one mid-bit shift strobe per data bit and checks the stop bit.
//  - It pulses packet_done, and pulses load_buffer only for good frames.
// PARAMETERS
//  CLKS_PER_BIT  10  clocks per serial bit; legal range 4..255
//  DATA_BITS     8   data bits per frame; legal range 1..16
// PORTS
//  clk                 in   1  system clock; all logic on posedge
//  rst                 in   1  synchronous reset, active-high
//  serial_in           in   1  synchronized serial line, idle = 1
//  start_bit_detected  in   1  1-cycle pulse from start-bit detector
//  shift_strobe        out  1  1-cycle pulse: shift serial_in into data shift register
//  packet_done         out  1  1-cycle pulse at end of every completed frame
//  load_buffer         out  1  1-cycle pulse: frame good, load receive buffer
//  framing_error       out  1  stop bit sampled 0; held until next accepted start
//  parity_error        out  1  parity mismatch (see CONFIGURATION); held like framing_error
//  busy                out  1  1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: on a rst=1 edge every output goes to 0, state -> IDLE, counters -> 0.
//    This applies mid-frame as well: the partial frame is discarded and no pulses are emitted.
//  - SAMPLE_PT = CLKS_PER_BIT/2 (integer division).
//  - clk_cnt runs 1..CLKS_PER_BIT then wraps to 1.
//  - bit_cnt counts completed data bit periods (0..DATA_BITS).
//  - States: IDLE, START, DATA, [PARITY], STOP, LOAD.
//  - IDLE
//    - start_bit_detected=1 at edge t -> START at t+1, clk_cnt=1, bit_cnt=0.
//    - Both error flags are cleared at that edge.
//    - start_bit_detected is ignored in every other state.
//  - START
//    - At clk_cnt==SAMPLE_PT: if serial_in==1 (false start), go to IDLE next cycle.
//      No pulses are emitted and the flags stay 0.
//    - At clk_cnt==CLKS_PER_BIT -> DATA, clk_cnt=1.
//  - DATA
//    - shift_strobe=1 exactly in cycles with clk_cnt==SAMPLE_PT.
//    - At clk_cnt==CLKS_PER_BIT: bit_cnt++. If bit_cnt reaches DATA_BITS, go to
//      STOP (or PARITY when enabled).
//  - STOP
//    - At clk_cnt==SAMPLE_PT: framing_error <= ~serial_in, then -> LOAD.
//    - The frame ends mid-stop-bit so that back-to-back frames are accepted.
//  - LOAD (one cycle)
//    - packet_done=1.
//    - load_buffer = ~framing_error & ~parity_error.
//    - Next state is IDLE.
//  - Timing: with start accepted at edge t, data bit k (0-based) is strobed at
//    cycle t+(k+1)*CLKS_PER_BIT+SAMPLE_PT. Default case: bit0 at t+15, bit7 at t+85.
//    Stop sample at t+(DATA_BITS+1)*CLKS_PER_BIT+SAMPLE_PT = t+95; LOAD at t+96; busy=0 at t+97.
//  - shift_strobe, packet_done and load_buffer are registered-state decodes; they are never
//    high for more than 1 cycle per event.
// CONFIGURATION
//  - RX_PARITY_EN defined:
//    - A PARITY state follows DATA and lasts one full bit period.
//    - Its sample at SAMPLE_PT sets parity_error <= par_acc ^ serial_in (even parity).
//    - par_acc is the XOR of serial_in over all shift_strobe cycles; it is cleared on start.
//    - Then -> STOP; the stop sample moves CLKS_PER_BIT later (t+105 default).
//  - RX_PARITY_EN undefined: no PARITY state, no par_acc; parity_error is tied to 0.
// STRUCTURE
//  - Package rx_timer_pkg holds:
//    - typedef enum logic [2:0] rx_state_t {IDLE,START,DATA,PARITY,STOP,LOAD}.
//    - function sample_pt(int cpb) returning cpb/2.
//  - Sub-module rx_bit_timer:
//    - Holds clk_cnt/bit_cnt with sync active-high reset, plus clear and enable.
//    - Outputs mid_pulse (clk_cnt==SAMPLE_PT) and end_pulse (clk_cnt==CLKS_PER_BIT).
//    - Counter widths are $clog2(CLKS_PER_BIT+1) and $clog2(DATA_BITS+1).
//  - rx_frame_timer holds the FSM, the error flags and the optional par_acc.
// TESTING
//  - Good frame, defaults, data 8'hA5 LSB first, stop=1:
//    -> 8 strobes at t+15..t+85 step 10; packet_done and load_buffer at t+96;
//       framing_error=0; busy low at t+97.
//  - Bad stop bit, serial_in=0 at t+95:
//    -> framing_error=1 from t+96; packet_done=1 and load_buffer=0 at t+96;
//       framing_error clears on the next accepted start.
//  - False start, serial_in returns to 1 by t+5:
//    -> no strobes, no done; busy=0 from t+6; a new start at t+10 is accepted normally.
//  - Mid-frame reset: rst=1 at t+40
//    -> next cycle all outputs 0, IDLE; no packet_done; a start_bit_detected during DATA
//       of a later frame is ignored (strobe count stays 8).
//  - Back-to-back frames: second start pulse at t+97
//    -> second frame's bit0 strobe at t+112; both frames load.
//  - RX_PARITY_EN, data 8'h07 (odd ones count), parity bit 0
//    -> parity_error=1; load_buffer=0; packet_done at t+106.

Source files
------------

// File: rtl/rx_frame_timer_pkg.sv
// Shared state encoding and timing helper for the receive frame timer.
package rx_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    LOAD
  } rx_state_t;

  function automatic int sample_pt(int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/rx_frame_timer_if.sv
// Signal bundle between the start-bit detector / shift register side and the receive timer.
interface rx_frame_timer_if;
  logic serial_in;
  logic start_bit_detected;
  logic shift_strobe;
  logic packet_done;
  logic load_buffer;
  logic framing_error;
  logic parity_error;
  logic busy;

  modport master (
    output serial_in,
    output start_bit_detected,
    input  shift_strobe,
    input  packet_done,
    input  load_buffer,
    input  framing_error,
    input  parity_error,
    input  busy
  );

  modport slave (
    input  serial_in,
    input  start_bit_detected,
    output shift_strobe,
    output packet_done,
    output load_buffer,
    output framing_error,
    output parity_error,
    output busy
  );
endinterface

// File: rtl/rx_frame_timer_bit_timer.sv
// Bit-period pacing: clk_cnt runs 1..CLKS_PER_BIT and wraps, bit_cnt counts finished data bits.
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  input  logic bit_en_i,
  output logic mid_pulse_o,
  output logic end_pulse_o,
  output logic last_bit_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CPB_C  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID_C  = CW'(sample_pt(CLKS_PER_BIT));
  localparam logic [BW-1:0] LAST_C = BW'(DATA_BITS - 1);

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;

  assign mid_pulse_o = (clk_cnt_q == MID_C);
  assign end_pulse_o = (clk_cnt_q == CPB_C);
  assign last_bit_o  = (bit_cnt_q == LAST_C);

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (clear_i) begin
      clk_cnt_d = CW'(1);
      bit_cnt_d = '0;
    end else if (en_i) begin
      clk_cnt_d = end_pulse_o ? CW'(1) : clk_cnt_q + CW'(1);
      if (bit_en_i && end_pulse_o) begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/rx_frame_timer.sv
// Receive frame sequencer: paces bits after a start, strobes data, checks stop (and parity).
// Optional even-parity bit enabled by defining RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for start_bit_detected
// START  | inside start bit, false-start check at mid-bit
// DATA   | data bits, shift_strobe at mid-bit
// PARITY | parity bit (RX_PARITY_EN only)
// STOP   | stop bit sampled at mid-bit
// LOAD   | one cycle: packet_done, load_buffer if frame good
module rx_frame_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input logic          clk,
  input logic          rst,
  rx_frame_timer_if.slave bus
);
`ifdef RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  rx_state_t state_q, state_d;
  logic      mid_pulse, end_pulse, last_bit;
  logic      start_acc;
  logic      shift_strobe, packet_done, load_buffer, busy;
  logic      framing_error_q, framing_error_d;
  logic      parity_error;

  assign start_acc = (state_q == IDLE) && bus.start_bit_detected;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (start_acc),
    .en_i       (state_q != IDLE),
    .bit_en_i   (state_q == DATA),
    .mid_pulse_o(mid_pulse),
    .end_pulse_o(end_pulse),
    .last_bit_o (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_bit_detected) state_d = START;
      START: begin
        if (mid_pulse && bus.serial_in) state_d = IDLE;
        else if (end_pulse)             state_d = DATA;
      end
      DATA:    if (end_pulse && last_bit) state_d = AFTER_DATA;
      PARITY:  if (end_pulse) state_d = STOP;
      STOP:    if (mid_pulse) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_strobe = 1'b0;
    packet_done  = 1'b0;
    load_buffer  = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      DATA: shift_strobe = mid_pulse;
      LOAD: begin
        packet_done = 1'b1;
        load_buffer = ~framing_error_q & ~parity_error;
      end
      default: ;
    endcase
  end

  // Error flags persist after the frame and clear only when the next start is accepted.
  always_comb begin
    framing_error_d = framing_error_q;
    if (start_acc) begin
      framing_error_d = 1'b0;
    end else if (state_q == STOP && mid_pulse) begin
      framing_error_d = ~bus.serial_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      framing_error_q <= 1'b0;
    end else begin
      framing_error_q <= framing_error_d;
    end
  end

`ifdef RX_PARITY_EN
  logic par_acc_q, par_acc_d;
  logic parity_error_q, parity_error_d;

  always_comb begin
    par_acc_d      = par_acc_q;
    parity_error_d = parity_error_q;
    if (start_acc) begin
      par_acc_d      = 1'b0;
      parity_error_d = 1'b0;
    end else begin
      if (shift_strobe) par_acc_d = par_acc_q ^ bus.serial_in;
      if (state_q == PARITY && mid_pulse) parity_error_d = par_acc_q ^ bus.serial_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_acc_q      <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      par_acc_q      <= par_acc_d;
      parity_error_q <= parity_error_d;
    end
  end

  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

  assign bus.shift_strobe  = shift_strobe;
  assign bus.packet_done   = packet_done;
  assign bus.load_buffer   = load_buffer;
  assign bus.framing_error = framing_error_q;
  assign bus.parity_error  = parity_error;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_rx_frame_timer.sv
// Bench for rx_frame_timer: frames are scheduled on a cycle timeline, expected outputs derived from frame timing.
module tb_rx_frame_timer;
  localparam int CPB  = 10;
  localparam int DB   = 8;
  localparam int SP   = CPB / 2;
`ifdef RX_PARITY_EN
  localparam int PEN  = 1;
`else
  localparam int PEN  = 0;
`endif
  localparam int FB   = DB + 1 + PEN;
  localparam int FLEN = FB * CPB + SP + 1;
  localparam int N    = 12000;

  logic clk = 1'b0;
  logic rst;

  rx_frame_timer_if bus ();

  rx_frame_timer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  bit ser [N];
  bit st  [N];
  bit rs  [N];
  bit e_busy [N];
  bit e_stb  [N];
  bit e_done [N];
  bit e_load [N];
  bit e_ferr [N];
  bit e_perr [N];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_flags(input int from, input bit f, input bit p);
    for (int n = from; n < N; n++) begin
      e_ferr[n] = f;
      e_perr[n] = p;
    end
  endtask

  // kind: 0 = full frame, 1 = false start, 2 = reset at t+roff; ign>0 adds an ignored start pulse
  task automatic sched(input int t, input int kind, input logic [DB-1:0] data, input bit stop_v,
                       input bit pflip, input int roff, input int ign, output int t_nx);
    int last;
    int s;
    bit b;
    bit pbit;
    pbit = (^data) ^ pflip;
    st[t] = 1'b1;
    fill_flags(t + 1, 1'b0, 1'b0);
    if (kind == 1) begin
      for (int c = 0; c < CPB; c++) ser[t + c] = (c < SP - 1) ? 1'b0 : 1'b1;
      last = t + SP;
    end else begin
      for (int j = 0; j <= FB; j++) begin
        if (j == 0)       b = 1'b0;
        else if (j <= DB) b = data[j-1];
        else if (j < FB)  b = pbit;
        else              b = stop_v;
        for (int c = 0; c < CPB; c++) ser[t + j*CPB + c] = b;
      end
      last = (kind == 2) ? t + roff : t + FLEN;
      for (int k = 0; k < DB; k++) begin
        s = t + (k + 1) * CPB + SP;
        if (s <= last) e_stb[s] = 1'b1;
      end
    end
    for (int n = t + 1; n <= last; n++) e_busy[n] = 1'b1;
    if (kind == 0) begin
      e_done[last] = 1'b1;
      e_load[last] = stop_v && !(PEN == 1 && pflip);
      fill_flags(last, !stop_v, (PEN == 1) ? pflip : 1'b0);
    end
    if (kind == 2) rs[t + roff] = 1'b1;
    if (ign > 0 && t + ign <= last) st[t + ign] = 1'b1;
    t_nx = last + 1;
  endtask

  initial begin
    int t, tn, t_fs, kind, r, roff, ign;
    logic [DB-1:0] data;
    logic [5:0] obs, exp;
    int n_stb, x_stb, n_done, x_done;

    rst = 1'b1;
    bus.serial_in = 1'b1;
    bus.start_bit_detected = 1'b0;
    for (int n = 0; n < N; n++) ser[n] = 1'b1;
    rs[0] = 1'b1; rs[1] = 1'b1; rs[2] = 1'b1;

    t = 20;
    sched(t, 0, 8'hA5, 1'b1, 1'b0, 0, 0, tn);
    sched(tn, 0, 8'h3C, 1'b1, 1'b0, 0, 0, tn);
    t = tn + 5;
    sched(t, 0, 8'h5A, 1'b0, 1'b0, 0, 0, tn);
    t_fs = tn + 3;
    sched(t_fs, 1, 8'h00, 1'b1, 1'b0, 0, 0, tn);
    sched(t_fs + 10, 0, 8'hC3, 1'b1, 1'b0, 0, 0, tn);
    t = tn + 4;
    sched(t, 2, 8'hFF, 1'b1, 1'b0, 40, 0, tn);
    t = tn + 2;
    sched(t, 0, 8'h81, 1'b1, 1'b0, 0, 30, tn);
    t = tn + 1;
    sched(t, 0, 8'h07, 1'b1, 1'b1, 0, 0, tn);
    t = tn;

    while (t < N - 2 * FLEN - 50) begin
      r     = $urandom_range(0, 9);
      kind  = (r == 7) ? 1 : (r == 8) ? 2 : 0;
      data  = DB'($urandom);
      roff  = $urandom_range(2, FLEN - 1);
      ign   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, FLEN) : 0;
      sched(t, kind, data, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, roff, ign, tn);
      t = tn + $urandom_range(0, 12);
    end

    n_stb = 0; x_stb = 0; n_done = 0; x_done = 0;
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      obs = {bus.busy, bus.shift_strobe, bus.packet_done, bus.load_buffer,
             bus.framing_error, bus.parity_error};
      exp = {e_busy[n], e_stb[n], e_done[n], e_load[n], e_ferr[n], e_perr[n]};
      check_eq($sformatf("outputs_cycle_%0d {busy,stb,done,load,ferr,perr}", n), 32'(obs), 32'(exp));
      if (bus.shift_strobe === 1'b1) n_stb++;
      if (bus.packet_done === 1'b1)  n_done++;
      if (e_stb[n])  x_stb++;
      if (e_done[n]) x_done++;
      rst = rs[n];
      bus.serial_in = ser[n];
      bus.start_bit_detected = st[n];
    end

    check_eq("strobe_total", 32'(n_stb), 32'(x_stb));
    check_eq("done_total", 32'(n_done), 32'(x_done));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
